bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one datapath resource (memory/register-bank port) among N_REQ requesters, e.g. the fetch, decode, execute and PC stages sequenced by the main control FSM.
- Grants exclusive ownership, holds the grant until the owner signals completion, then inserts one turnaround cycle before the next owner.
- Registered Moore-style outputs throughout.

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_arbiter_if.sv | 27 ++
 rtl/bus_arbiter_rr_picker.sv | 34 +++
 rtl/bus_arbiter.sv | 129 ++++++++++++
 tb/tb_bus_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter.
// State encodings and default sizing.
package bus_arbiter_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int IDX_W_DEF    = 2;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, busy, owner, timeout
  );

  modport slave (
    input  req, done,
    output grant, busy, owner, timeout
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Rotating priority encoder: first set req bit after last,
// wrapping modulo N_REQ.
module bus_arbiter_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] sel
);

  // distance from last+1 decides priority; smallest wins
  always_comb begin
    int best;
    int d;
    any  = 1'b0;
    sel  = '0;
    best = N_REQ;
    d    = 0;
    for (int j = 0; j < N_REQ; j++) begin
      d = j - int'(last) - 1;
      if (d < 0) d = d + N_REQ;
      if (req[j] && d < best) begin
        best = d;
        any  = 1'b1;
        sel  = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter with one-cycle release turnaround.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic        clk,
  input logic        rst,
  bus_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 8 || (2 ** IDX_W) < N_REQ
      || MAX_HOLD < 2) begin : g_bad_cfg
    $error("bus_arbiter: bad parameter set");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             timeout_d;
  logic             any;
  logic [IDX_W-1:0] sel;
  logic             wd_fire;
  logic             own_done;
  logic             own_req;

  bus_arbiter_rr_picker #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req (bus.req),
    .last(last_q),
    .any (any),
    .sel (sel)
  );

  assign own_done = bus.done[owner_q];
  assign own_req  = bus.req[owner_q];

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  // hold count: zero on the first grant cycle, +1 per grant cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_q != ARB_GRANT) hold_q <= '0;
      else                      hold_q <= hold_q + 1'b1;
    end
  end

  assign wd_fire     = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign bus.timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ARB_IDLE, ARB_RELEASE: begin
        if (any) begin
          state_d = ARB_GRANT;
          grant_d = N_REQ'(1) << sel;
          busy_d  = 1'b1;
          owner_d = sel;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ARB_GRANT: begin
        if (own_done || !own_req || wd_fire) begin
          state_d   = ARB_RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          last_d    = owner_q;
          timeout_d = wd_fire && !own_done && own_req;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        owner_d = '0;
      end
    endcase
  end

  // state, pointer and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter.
// Covers ARB_TIMEOUT_EN defined or not.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arbiter_if #(.N_REQ(4), .IDX_W(2)) bus ();

  bus_arbiter #(
    .N_REQ(4),
    .IDX_W(2),
    .MAX_HOLD(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_g;
    int held;
    int to_seen;
    bus.req  = '0;
    bus.done = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_tmo", 32'(bus.timeout), 32'h0);

    // single request
    bus.req = 4'b0100;
    tick();
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_owner", 32'(bus.owner), 32'h2);
    chk("single_busy", 32'(bus.busy), 32'h1);
    bus.done = 4'b0100;
    tick();
    chk("single_rel_g", 32'(bus.grant), 32'h0);
    chk("single_rel_b", 32'(bus.busy), 32'h0);
    chk("single_rel_own", 32'(bus.owner), 32'h2);
    bus.done = '0;
    bus.req  = '0;
    tick();
    chk("single_idle_g", 32'(bus.grant), 32'h0);
    tick();
    chk("single_idle2_g", 32'(bus.grant), 32'h0);

    // round robin from fresh pointer
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk("rr_g1", 32'(bus.grant), 32'(exp_g));
      chk("rr_own", 32'(bus.owner), 32'(k % 4));
      tick();
      chk("rr_g2", 32'(bus.grant), 32'(exp_g));
      bus.done = exp_g;
      tick();
      chk("rr_gap", 32'(bus.grant), 32'h0);
      bus.done = '0;
      tick();
    end

    // pointer now at 0, in grant for requester 1 (req=1111)
    chk("nod_own1", 32'(bus.grant), 32'h2);
    bus.req  = 4'b0010;
    bus.done = 4'b1000;
    tick();
    chk("nod_hold", 32'(bus.grant), 32'h2);
    bus.done = 4'b0010;
    bus.req  = 4'b1001;
    tick();
    chk("nod_rel", 32'(bus.grant), 32'h0);
    bus.done = '0;
    tick();
    chk("nod_next3", 32'(bus.grant), 32'h8);
    chk("nod_own3", 32'(bus.owner), 32'h3);

    // hand over to 0, then abandon
    bus.done = 4'b1000;
    bus.req  = 4'b0001;
    tick();
    chk("ab_gap", 32'(bus.grant), 32'h0);
    bus.done = '0;
    tick();
    chk("ab_own0", 32'(bus.grant), 32'h1);
    bus.req = '0;
    tick();
    chk("ab_rel_g", 32'(bus.grant), 32'h0);
    chk("ab_rel_b", 32'(bus.busy), 32'h0);
    bus.req = 4'b0011;
    tick();
    chk("ab_last0", 32'(bus.grant), 32'h2);

    // async reset mid-grant
    #2;
    rst = 1'b1;
    #1;
    chk("ar_grant", 32'(bus.grant), 32'h0);
    chk("ar_busy", 32'(bus.busy), 32'h0);
    chk("ar_owner", 32'(bus.owner), 32'h0);
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk("ar_first0", 32'(bus.grant), 32'h1);

    // long hold on a single owner
    do_reset();
    bus.req = 4'b0100;
    tick();
    chk("hold_start", 32'(bus.grant), 32'h4);
`ifdef ARB_TIMEOUT_EN
    held = 1;
    to_seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.grant == 4'b0100) held++;
      if (bus.timeout) to_seen++;
    end
    chk("wd_held", 32'(held), 32'd16);
    chk("wd_quiet", 32'(to_seen), 32'd0);
    tick();
    chk("wd_drop", 32'(bus.grant), 32'h0);
    chk("wd_pulse", 32'(bus.timeout), 32'h1);
    tick();
    chk("wd_regrant", 32'(bus.grant), 32'h4);
    chk("wd_pulse_end", 32'(bus.timeout), 32'h0);
`else
    held = 1;
    to_seen = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus.grant == 4'b0100) held++;
      if (bus.timeout) to_seen++;
    end
    chk("nowd_held", 32'(held), 32'd121);
    chk("nowd_tmo", 32'(to_seen), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
